sa_feeder_3x3: RTL

Operand staging and skew stage that sits directly upstream of the 3x3 systolic array.
- Holds one 3x3 A matrix and one 3x3 B matrix, loaded through a simple write port.
- On start, streams them diagonally skewed into the array's A_in_1..3 / B_in_1..3 inputs and drives the array's PE enable.
- After a configurable drain interval, pulses done.

---
 rtl/sa_feeder_3x3_if.sv | 26 ++
 rtl/sa_feeder_3x3.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sa_feeder_3x3_if.sv
// Write/start port and skewed-feed outputs between the operand feeder and its
// host/array. The master drives the writes and start; the slave is the feeder.
interface sa_feeder_3x3_if #(
  parameter int DW = 8
);
  logic          wr_en;
  logic          wr_sel;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          pe_en;
  logic          done;
  logic [DW-1:0] A_out_1, A_out_2, A_out_3;
  logic [DW-1:0] B_out_1, B_out_2, B_out_3;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, pe_en, done, A_out_1, A_out_2, A_out_3, B_out_1, B_out_2, B_out_3
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, pe_en, done, A_out_1, A_out_2, A_out_3, B_out_1, B_out_2, B_out_3
  );
endinterface

// File: rtl/sa_feeder_3x3.sv
// Holds a 3x3 A and B operand pair and streams them diagonally skewed into a
// 3x3 systolic array, then pulses done after a fixed drain interval.
module sa_feeder_3x3 #(
  parameter int DW        = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic           clk,
  input  logic           rst,
  sa_feeder_3x3_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  localparam int DCW = $clog2(DRAIN_CYC + 1);

  state_t         state_q, state_d;
  logic [2:0]     t_q, t_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [DW-1:0]  a_q [3][3];
  logic [DW-1:0]  a_d [3][3];
  logic [DW-1:0]  b_q [3][3];
  logic [DW-1:0]  b_d [3][3];
  logic [DW-1:0]  a_out_q [3];
  logic [DW-1:0]  a_out_d [3];
  logic [DW-1:0]  b_out_q [3];
  logic [DW-1:0]  b_out_d [3];
  logic           busy_q, busy_d;
  logic           pe_en_q, pe_en_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (t_q == 3'd4) begin
          state_d = DRAIN;
          t_d     = '0;
          drain_d = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          state_d = DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Exact address match also rejects the unused indices 9..15.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a_d[r][c] = a_q[r][c];
        b_d[r][c] = b_q[r][c];
        if (bus.wr_en && !busy_q && (bus.wr_addr == 4'(r * 3 + c))) begin
          if (bus.wr_sel) b_d[r][c] = bus.wr_data;
          else            a_d[r][c] = bus.wr_data;
        end
      end
    end
  end

  // Outputs are computed from next state and next storage so a write landing
  // on the start edge is already visible at beat 0.
  always_comb begin
    busy_d  = (state_d == STREAM) || (state_d == DRAIN);
    pe_en_d = (state_d == STREAM);
    done_d  = (state_d == DONE);
    for (int r = 0; r < 3; r++) begin
      a_out_d[r] = '0;
      b_out_d[r] = '0;
      if (state_d == STREAM) begin
        for (int k = 0; k < 3; k++) begin
          if (int'(t_d) == r + k) begin
            a_out_d[r] = a_d[r][k];
            b_out_d[r] = b_d[k][r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      pe_en_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        a_out_q[r] <= '0;
        b_out_q[r] <= '0;
        for (int c = 0; c < 3; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      pe_en_q <= pe_en_d;
      done_q  <= done_d;
      for (int r = 0; r < 3; r++) begin
        a_out_q[r] <= a_out_d[r];
        b_out_q[r] <= b_out_d[r];
        for (int c = 0; c < 3; c++) begin
          a_q[r][c] <= a_d[r][c];
          b_q[r][c] <= b_d[r][c];
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.pe_en   = pe_en_q;
  assign bus.done    = done_q;
  assign bus.A_out_1 = a_out_q[0];
  assign bus.A_out_2 = a_out_q[1];
  assign bus.A_out_3 = a_out_q[2];
  assign bus.B_out_1 = b_out_q[0];
  assign bus.B_out_2 = b_out_q[1];
  assign bus.B_out_3 = b_out_q[2];
endmodule
